// File: rtl/uart_state_tx.sv
//==============================================================================
// Module      : uart_state_tx
// Description : 8N1 UART transmitter that sends one ASCII line holding a
//               snapshot of PC and R0..R7 as hex bytes, ending in CR LF.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_state_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic [7:0] iPC,
    input  logic [7:0] iR0,
    input  logic [7:0] iR1,
    input  logic [7:0] iR2,
    input  logic [7:0] iR3,
    input  logic [7:0] iR4,
    input  logic [7:0] iR5,
    input  logic [7:0] iR6,
    input  logic [7:0] iR7,
    output logic       oTXD,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic [1:0]  c_idle      = 2'd0;
    localparam logic [1:0]  c_start     = 2'd1;
    localparam logic [1:0]  c_data      = 2'd2;
    localparam logic [1:0]  c_stop      = 2'd3;
    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  c_last_char = 5'd27;

    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;
    logic [4:0]  chr_q,   chr_d;
    logic        txd_q,   txd_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [7:0]  snap_q [9];
    logic [7:0]  snap_d [9];

    logic [3:0]  w_sel;
    logic [1:0]  w_pos;
    logic [7:0]  w_byte;
    logic [7:0]  w_char;
    logic [2:0]  w_next_bit;
    logic        w_bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Three characters per byte: high nibble, low nibble, separator.
    assign w_sel      = 4'(chr_q / 5'd3);
    assign w_pos      = 2'(chr_q % 5'd3);
    assign w_byte     = (w_sel <= 4'd8) ? snap_q[w_sel] : 8'h00;
    assign w_next_bit = bit_q + 3'd1;
    assign w_bit_end  = (baud_q == c_bit_last);

    always_comb begin
        w_char = 8'h0A;
        if (chr_q != c_last_char) begin
            case (w_pos)
                2'd0:    w_char = hex_ascii(w_byte[7:4]);
                2'd1:    w_char = hex_ascii(w_byte[3:0]);
                default: w_char = (w_sel == 4'd8) ? 8'h0D : 8'h20;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            snap_d[i] = snap_q[i];
        end

        case (state_q)
            c_idle: begin
                // The cycle that shows oDone still belongs to the finished line.
                if (iStart && !done_q) begin
                    state_d   = c_start;
                    baud_d    = '0;
                    bit_d     = '0;
                    chr_d     = '0;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    snap_d[0] = iPC;
                    snap_d[1] = iR0;
                    snap_d[2] = iR1;
                    snap_d[3] = iR2;
                    snap_d[4] = iR3;
                    snap_d[5] = iR4;
                    snap_d[6] = iR5;
                    snap_d[7] = iR6;
                    snap_d[8] = iR7;
                end
            end
            c_start: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = c_data;
                    txd_d   = w_char[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            c_data: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = c_stop;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = w_next_bit;
                        txd_d = w_char[w_next_bit];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            c_stop: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (chr_q == c_last_char) begin
                        state_d = c_idle;
                        chr_d   = '0;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = c_start;
                        chr_d   = chr_q + 5'd1;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= c_idle;
            baud_q  <= '0;
            bit_q   <= '0;
            chr_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign oTXD  = txd_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_state_tx.sv
//==============================================================================
// Module      : tb_uart_state_tx
// Description : Directed, table-driven bench for uart_state_tx (CLKS_PER_BIT=4).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_state_tx;

    localparam int CPB  = 4;
    localparam int LINE = 280 * CPB;
    localparam int CHAR = 10 * CPB;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iPC = '0, iR0 = '0, iR1 = '0, iR2 = '0, iR3 = '0;
    logic [7:0] iR4 = '0, iR5 = '0, iR6 = '0, iR7 = '0;
    logic       oTXD, oBusy, oDone;

    always #5 iCLK = ~iCLK;

    uart_state_tx #(.CLKS_PER_BIT(CPB)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart),
        .iPC(iPC), .iR0(iR0), .iR1(iR1), .iR2(iR2), .iR3(iR3),
        .iR4(iR4), .iR5(iR5), .iR6(iR6), .iR7(iR7),
        .oTXD(oTXD), .oBusy(oBusy), .oDone(oDone)
    );

    typedef struct packed {
        logic [7:0]      pc;
        logic [7:0][7:0] r;
        logic [223:0]    text;
    } vec_t;

    vec_t vecs [3];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ci     = 0;
    logic txd_s  [2600];
    logic busy_s [2600];
    logic done_s [2600];

    function automatic vec_t mk(input logic [7:0] pc, input logic [63:0] r_hi_to_lo,
                                input logic [223:0] text);
        vec_t v;
        v.pc   = pc;
        v.r    = r_hi_to_lo;
        v.text = text;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge iCLK);
        txd_s[ci]  = oTXD;
        busy_s[ci] = oBusy;
        done_s[ci] = oDone;
        ci++;
    endtask

    task automatic apply_vec(input vec_t v);
        iPC = v.pc;
        iR0 = v.r[0]; iR1 = v.r[1]; iR2 = v.r[2]; iR3 = v.r[3];
        iR4 = v.r[4]; iR5 = v.r[5]; iR6 = v.r[6]; iR7 = v.r[7];
    endtask

    // kind 1: corrupt R1 and request again; kind 2: request only;
    // kind 3: load vector 1 and request.
    task automatic run(input int n, input int inj_at, input int inj_kind);
        for (int i = 0; i < n; i++) begin
            step();
            iStart = 1'b0;
            if (i == inj_at) begin
                if (inj_kind == 1) iR1 = 8'h11;
                if (inj_kind == 3) apply_vec(vecs[1]);
                iStart = 1'b1;
            end
        end
    endtask

    task automatic check_line(input int base, input logic [223:0] txt, input string tag);
        int         lvl_err;
        int         blen;
        int         dcnt;
        logic [7:0] exp_c;
        logic [7:0] got_c;
        logic [9:0] frame;
        lvl_err = 0;
        blen    = 0;
        dcnt    = 0;
        for (int k = 0; k < 28; k++) begin
            exp_c = txt[(27 - k) * 8 +: 8];
            frame = {1'b1, exp_c, 1'b0};
            for (int b = 0; b < 8; b++) begin
                got_c[b] = txd_s[base + k * CHAR + (b + 1) * CPB + 1];
            end
            for (int j = 0; j < 10; j++) begin
                for (int s = 0; s < CPB; s++) begin
                    if (txd_s[base + k * CHAR + j * CPB + s] !== frame[j]) lvl_err++;
                end
            end
            chk($sformatf("%s char%0d", tag, k), {24'h0, got_c}, {24'h0, exp_c});
        end
        chk($sformatf("%s bit_levels", tag), lvl_err, 0);
        while (blen < LINE + 10 && busy_s[base + blen] === 1'b1) blen++;
        chk($sformatf("%s busy_len", tag), blen, LINE);
        for (int i = 0; i < LINE; i++) begin
            if (done_s[base + i] !== 1'b0) dcnt++;
        end
        chk($sformatf("%s done_early", tag), dcnt, 0);
        chk($sformatf("%s done_end", tag), {31'h0, done_s[base + LINE]}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int cnt;

        vecs[0] = mk(8'h1A, {8'h09, 8'h80, 8'h7E, 8'h3C, 8'hA0, 8'h05, 8'hFF, 8'h00},
                     "1A 00 FF 05 A0 3C 7E 80 09\r\n");
        vecs[1] = mk(8'h9B, {8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12},
                     "9B 12 34 56 78 9A BC DE F0\r\n");
        vecs[2] = mk(8'hFF, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                     "FF 00 00 00 00 00 00 00 00\r\n");

        // Reset and idle behaviour
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rst txd", {31'h0, oTXD}, 1);
        chk("rst busy", {31'h0, oBusy}, 0);
        chk("rst done", {31'h0, oDone}, 0);
        iRST_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            if (oTXD !== 1'b1 || oBusy !== 1'b0 || oDone !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Table-driven lines
        for (int v = 0; v < 3; v++) begin
            apply_vec(vecs[v]);
            iStart = 1'b1;
            ci = 0;
            run(LINE + 8, -1, 0);
            check_line(0, vecs[v].text, $sformatf("vec%0d", v));
            if (v == 0) begin
                chk("first_char_next_start", {30'h0, txd_s[CHAR - 1], txd_s[CHAR]}, 2'b10);
            end
        end

        // Snapshot isolation and busy-ignore
        apply_vec(vecs[0]);
        iStart = 1'b1;
        ci = 0;
        run(LINE + 40, 200, 1);
        check_line(0, vecs[0].text, "snap");
        cnt = 0;
        for (int i = LINE; i < LINE + 40; i++) begin
            if (busy_s[i] !== 1'b0 || txd_s[i] !== 1'b1) cnt++;
        end
        chk("snap no_second_line", cnt, 0);

        // Reset mid-line
        apply_vec(vecs[1]);
        iStart = 1'b1;
        ci = 0;
        run(537, -1, 0);
        #2 iRST_N = 1'b0;
        #1;
        chk("midrst txd", {31'h0, oTXD}, 1);
        chk("midrst busy", {31'h0, oBusy}, 0);
        chk("midrst done", {31'h0, oDone}, 0);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (oDone !== 1'b0 || oBusy !== 1'b0 || oTXD !== 1'b1) cnt++;
        end
        chk("midrst quiet", cnt, 0);
        apply_vec(vecs[2]);
        iStart = 1'b1;
        ci = 0;
        run(LINE + 8, -1, 0);
        check_line(0, vecs[2].text, "post_rst");

        // Request coincident with oDone is dropped
        apply_vec(vecs[0]);
        iStart = 1'b1;
        ci = 0;
        run(LINE + 12, LINE, 2);
        check_line(0, vecs[0].text, "coinc");
        cnt = 0;
        for (int i = LINE; i < LINE + 12; i++) begin
            if (busy_s[i] !== 1'b0) cnt++;
        end
        chk("coinc ignored", cnt, 0);

        // Request on the cycle after oDone starts the next line at once
        apply_vec(vecs[0]);
        iStart = 1'b1;
        ci = 0;
        run(2 * LINE + 12, LINE + 1, 3);
        check_line(0, vecs[0].text, "b2b_first");
        chk("b2b start", {30'h0, busy_s[LINE + 2], txd_s[LINE + 2]}, 2'b10);
        check_line(LINE + 2, vecs[1].text, "b2b_second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_state_tx.md
Name: uart_state_tx

Overview:
- UART 8N1 transmitter that streams a debug snapshot of the processor state (PC and registers R0..R7) as one ASCII text line on UART_TXD.
- The processor only writes into the register file and PC; this block is the reader/output end of that state, the serial counterpart of the LCD readout.
- Sits at top level: CPU state buses in, oTXD out to UART_TXD. A start pulse comes from a debounced KEY or from the CPU clock edge.

Parameters:
- CLKS_PER_BIT, 434, iCLK cycles per UART bit (50 MHz / 115200). Legal range 2..65535; benches use 4.

Ports:
- iCLK  input  1  system clock (CLOCK_50).
- iRST_N  input  1  asynchronous active-low reset.
- iStart  input  1  request one snapshot line; sampled on rising iCLK.
- iPC  input  8  program counter value.
- iR0..iR7  input  8 each  register file contents R0..R7 (eight separate ports).
- oTXD  output  1  serial line, idle high.
- oBusy  output  1  high while a line is being transmitted.
- oDone  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async, iRST_N=0): oTXD=1, oBusy=0, oDone=0, FSM=IDLE, all counters=0.
  - Reset mid-line aborts immediately: oTXD returns high with no partial-frame completion.
  - No oDone is generated for the aborted line.
- Snapshot: on the edge where iStart=1 in IDLE, latch iPC and iR0..iR7 into nine internal bytes.
  - Later input changes do not affect the line in progress.
  - iStart while oBusy=1 is ignored; there is no queueing.
- Line format: 28 characters, in this order:
  - PC, R0, R1, ..., R7, each as two uppercase hex digits, high nibble first.
  - 0x20 (space) between bytes.
  - 0x0D, 0x0A after R7.
  - Nibble mapping: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
- Character frame:
  - start bit 0;
  - 8 data bits, LSB first;
  - 1 stop bit 1;
  - each bit exactly CLKS_PER_BIT cycles.
  - Characters follow back-to-back: the next start bit begins on the cycle after the previous stop bit ends, with no idle gap.
- FSM states:
  - IDLE -> START on accepted iStart.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if characters remain, else -> IDLE.
- Timing:
  - oTXD and oBusy are registered outputs. Both change on the same edge that accepts iStart (oTXD=0, oBusy=1).
  - The line occupies exactly 280*CLKS_PER_BIT cycles.
  - On the edge ending the last stop bit: oBusy=0, oDone=1 for one cycle, FSM=IDLE.
  - iStart=1 on the same cycle that oDone=1 is ignored (FSM still finishing). iStart is accepted on the following cycle.
- Counters:
  - Bit-time counter counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index counts 0..7.
  - Character index counts 0..27; index 27 is terminal.
  - Character generation: index / 3 selects the byte; index mod 3 selects high nibble, low nibble, or separator. The separator is space for bytes 0..7 and CR for byte 8; index 27 is LF.
- oTXD is glitch-free: driven only from a flop, never combinationally.

Test Plan:
- Reset idle: hold iRST_N=0 with CLKS_PER_BIT=4 -> oTXD=1, oBusy=0, oDone=0. Release reset with iStart=0 for 100 cycles -> outputs unchanged.
- Basic line: iPC=0x1A, iR0=0x00, iR1=0xFF, iR2=0x05, iR3=0xA0, iR4=0x3C, iR5=0x7E, iR6=0x80, iR7=0x09; pulse iStart.
  - Decoded UART text must be "1A 00 FF 05 A0 3C 7E 80 09\r\n" (28 bytes).
  - oBusy must be high for exactly 1120 cycles; oDone pulses once at cycle 1120.
- Bit timing: first character '1' (0x31) -> oTXD sequence 0,1,0,0,0,1,1,0,0,1. Each level must hold exactly 4 cycles, and the next start bit must fall exactly on cycle 40.
- Snapshot isolation and busy ignore: change iR1 to 0x11 and pulse iStart at cycle 200 of a line -> line text unchanged, total length still 1120 cycles, no second line follows.
- Reset mid-line: assert iRST_N=0 at cycle 537 -> oTXD=1 and oBusy=0 asynchronously, with no oDone. After release, a new iStart produces a complete correct line.
- Back-to-back: pulse iStart on the cycle after oDone -> second line starts immediately, correct text. A pulse coincident with oDone -> ignored.
